mio_bus_ctrl: RTL and testbench

Memory/IO bus controller sitting directly downstream of the multi-cycle CPU core. It accepts the core's single outstanding bus request (breq, mem_w, address, write data) and decodes it to either the synchronous block RAM or the peripheral IO port. It sequences fixed-latency RAM access and handshaked IO access with timeout, then returns read data and a one-cycle MIO_ready pulse that releases the core's memory state.

---
 rtl/mio_bus_ctrl.sv | 123 ++++++++++++
 tb/tb_mio_bus_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_ctrl.sv
// rtl/mio_bus_ctrl.sv - memory/IO bus controller between CPU core, block RAM and IO port
module mio_bus_ctrl #(
   parameter int RAM_AW     = 12,
   parameter int RAM_LAT    = 1,
   parameter int IO_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              breq,
   input  logic              mem_w,
   input  logic [31:0]       addr_in,
   input  logic [31:0]       data_from_cpu,
   output logic [31:0]       data_to_cpu,
   output logic              MIO_ready,
   output logic              ram_en,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout,
   output logic              io_sel,
   output logic              io_we,
   output logic [7:0]        io_addr,
   output logic [31:0]       io_wdata,
   input  logic [31:0]       io_rdata,
   input  logic              io_ack,
   output logic              bus_err,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, RAM_WAIT, IO_WAIT, DONE} state_t;

   state_t     state;
   logic [2:0] ram_cnt;
   logic [7:0] io_cnt;
   logic       we_q;

   // Only a subset of the address bits is decoded; the rest alias.
   logic unused_addr;
   assign unused_addr = ^addr_in;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         ram_cnt     <= '0;
         io_cnt      <= '0;
         we_q        <= 1'b0;
         data_to_cpu <= '0;
         MIO_ready   <= 1'b0;
         ram_en      <= 1'b0;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_din     <= '0;
         io_sel      <= 1'b0;
         io_we       <= 1'b0;
         io_addr     <= '0;
         io_wdata    <= '0;
         bus_err     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         MIO_ready <= 1'b0;
         bus_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (breq) begin
                  we_q <= mem_w;
                  busy <= 1'b1;
                  if (addr_in[31:29] == 3'b111) begin
                     state    <= IO_WAIT;
                     io_sel   <= 1'b1;
                     io_we    <= mem_w;
                     io_addr  <= addr_in[9:2];
                     io_wdata <= data_from_cpu;
                     io_cnt   <= '0;
                  end else begin
                     state    <= RAM_WAIT;
                     ram_en   <= 1'b1;
                     ram_we   <= mem_w;
                     ram_addr <= addr_in[RAM_AW+1:2];
                     ram_din  <= data_from_cpu;
                     ram_cnt  <= RAM_LAT[2:0];
                  end
               end
            end
            RAM_WAIT: begin
               if (ram_cnt == 3'd0) begin
                  data_to_cpu <= we_q ? 32'h0 : ram_dout;
                  MIO_ready   <= 1'b1;
                  state       <= DONE;
               end else begin
                  ram_cnt <= ram_cnt - 3'd1;
               end
            end
            IO_WAIT: begin
               // Ack is checked first so a same-cycle ack beats the timeout.
               if (io_ack) begin
                  data_to_cpu <= we_q ? 32'h0 : io_rdata;
                  MIO_ready   <= 1'b1;
                  io_sel      <= 1'b0;
                  io_we       <= 1'b0;
                  state       <= DONE;
               end else if (io_cnt == IO_TIMEOUT[7:0]) begin
                  data_to_cpu <= 32'h0;
                  MIO_ready   <= 1'b1;
                  bus_err     <= 1'b1;
                  io_sel      <= 1'b0;
                  io_we       <= 1'b0;
                  state       <= DONE;
               end else begin
                  io_cnt <= io_cnt + 8'd1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb/tb_mio_bus_ctrl.sv - randomized self-checking bench for mio_bus_ctrl
module tb_mio_bus_ctrl;
   localparam int RAM_AW     = 12;
   localparam int RAM_LAT    = 1;
   localparam int IO_TIMEOUT = 3;

   logic              clk = 1'b0;
   logic              reset, breq, mem_w, io_ack;
   logic [31:0]       addr_in, data_from_cpu, io_rdata;
   logic [31:0]       data_to_cpu, ram_din, io_wdata;
   logic              MIO_ready, ram_en, ram_we, io_sel, io_we, bus_err, busy;
   logic [RAM_AW-1:0] ram_addr;
   logic [7:0]        io_addr;
   logic [31:0]       ram_dout;

   int n_checks = 0;
   int n_errors = 0;

   mio_bus_ctrl #(.RAM_AW(RAM_AW), .RAM_LAT(RAM_LAT), .IO_TIMEOUT(IO_TIMEOUT)) dut (
      .clk(clk), .reset(reset), .breq(breq), .mem_w(mem_w), .addr_in(addr_in),
      .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu), .MIO_ready(MIO_ready),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout), .io_sel(io_sel), .io_we(io_we), .io_addr(io_addr),
      .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack), .bus_err(bus_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Synchronous block RAM with one cycle of read latency.
   logic [31:0] ram_mem [0:(1<<RAM_AW)-1];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) ram_mem[ram_addr] <= ram_din;
         ram_dout <= ram_mem[ram_addr];
      end
   end

   // Reference memory keyed by word index derived from the byte address.
   logic [31:0] ref_mem [int];

   function automatic int word_of(input logic [31:0] a);
      return int'((a >> 2) % (32'd1 << RAM_AW));
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input int ack_cyc, input bit hold, input logic [31:0] rdata);
      bit          is_io;
      int          exp_ready, ready_cyc, w;
      logic [31:0] exp_data;
      bit          exp_err;
      @(negedge clk);
      io_ack = 1'b0;
      check("idle_busy", {31'b0, busy}, 32'h0);
      breq = 1'b1; mem_w = wr; addr_in = addr; data_from_cpu = data; io_rdata = rdata;
      is_io = (addr[31:28] == 4'hE) || (addr[31:28] == 4'hF);
      w = word_of(addr);
      if (is_io) begin
         if (ack_cyc >= 1 && ack_cyc <= IO_TIMEOUT + 1) begin
            exp_ready = ack_cyc + 1; exp_err = 1'b0; exp_data = wr ? 32'h0 : rdata;
         end else begin
            exp_ready = IO_TIMEOUT + 2; exp_err = 1'b1; exp_data = 32'h0;
         end
      end else begin
         exp_ready = RAM_LAT + 2; exp_err = 1'b0;
         exp_data  = wr ? 32'h0 : (ref_mem.exists(w) ? ref_mem[w] : 32'h0);
         if (wr) ref_mem[w] = data;
      end
      @(posedge clk);
      ready_cyc = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            check("busy_active", {31'b0, busy}, 32'h1);
            if (is_io) begin
               check("io_addr", {24'b0, io_addr}, {24'b0, addr[9:2]});
               check("io_we", {31'b0, io_we}, {31'b0, wr});
               if (wr) check("io_wdata", io_wdata, data);
               check("ram_en_on_io", {31'b0, ram_en}, 32'h0);
            end else begin
               check("ram_en", {31'b0, ram_en}, 32'h1);
               check("ram_we", {31'b0, ram_we}, {31'b0, wr});
               check("ram_addr", {20'b0, ram_addr}, w);
               if (wr) check("ram_din", ram_din, data);
            end
            if (!hold) breq = 1'b0;
            mem_w = 1'($urandom); addr_in = $urandom; data_from_cpu = $urandom;
         end else if (cyc == 2 && !is_io) begin
            check("ram_en_pulse", {31'b0, ram_en}, 32'h0);
         end
         if (is_io && !MIO_ready) check("io_sel_held", {31'b0, io_sel}, 32'h1);
         io_ack = is_io ? (cyc == ack_cyc) : 1'($urandom);
         if (MIO_ready) begin
            ready_cyc = cyc;
            check("data_to_cpu", data_to_cpu, exp_data);
            check("bus_err", {31'b0, bus_err}, {31'b0, exp_err});
            check("io_sel_done", {31'b0, io_sel}, 32'h0);
            check("busy_done", {31'b0, busy}, 32'h1);
            break;
         end
      end
      check("ready_cycle", ready_cyc, exp_ready);
      if (!hold) breq = 1'b0;
   endtask

   initial begin
      int en_c[$];
      int rdy_c[$];
      logic [31:0] a;
      for (int i = 0; i < (1 << RAM_AW); i++) ram_mem[i] = 32'h0;
      ram_dout = 32'h0;
      reset = 1'b1; breq = 1'b0; mem_w = 1'b0; io_ack = 1'b0;
      addr_in = '0; data_from_cpu = '0; io_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_data", data_to_cpu, 32'h0);
      check("rst_ready", {31'b0, MIO_ready}, 32'h0);
      check("rst_ram_en", {31'b0, ram_en}, 32'h0);
      check("rst_ram_we", {31'b0, ram_we}, 32'h0);
      check("rst_ram_addr", {20'b0, ram_addr}, 32'h0);
      check("rst_ram_din", ram_din, 32'h0);
      check("rst_io_sel", {31'b0, io_sel}, 32'h0);
      check("rst_io_we", {31'b0, io_we}, 32'h0);
      check("rst_io_addr", {24'b0, io_addr}, 32'h0);
      check("rst_io_wdata", io_wdata, 32'h0);
      check("rst_bus_err", {31'b0, bus_err}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      reset = 1'b0;

      do_txn(1'b1, 32'h0000_0010, 32'h1234_5678, 0, 1'b0, 32'h0);
      do_txn(1'b0, 32'h0000_0010, 32'h0, 0, 1'b0, 32'h0);
      do_txn(1'b0, 32'h0000_4010, 32'h0, 0, 1'b1, 32'h0);
      do_txn(1'b0, 32'h0000_0013, 32'h0, 0, 1'b0, 32'h0);
      do_txn(1'b0, 32'hE000_0004, 32'h0, 4, 1'b0, 32'hCAFE_0001);
      do_txn(1'b0, 32'hF000_0100, 32'h0, 0, 1'b0, 32'h5555_AAAA);
      do_txn(1'b1, 32'hE000_03FC, 32'hDEAD_BEEF, 1, 1'b0, 32'h7777_7777);

      // breq held across two reads: expect ram_en at 1 and 5, MIO_ready at 3 and 7.
      @(negedge clk);
      io_ack = 1'b0; breq = 1'b1; mem_w = 1'b0; addr_in = 32'h0000_0010;
      @(posedge clk);
      for (int cyc = 1; cyc <= 7; cyc++) begin
         @(negedge clk);
         if (ram_en) en_c.push_back(cyc);
         if (MIO_ready) begin
            rdy_c.push_back(cyc);
            check("b2b_data", data_to_cpu, 32'h1234_5678);
         end
         if (cyc == 7) breq = 1'b0;
      end
      check("b2b_en_count", en_c.size(), 2);
      check("b2b_rdy_count", rdy_c.size(), 2);
      if (en_c.size() == 2 && rdy_c.size() == 2) begin
         check("b2b_en2_cycle", en_c[1], 5);
         check("b2b_rdy2_cycle", rdy_c[1], 7);
      end

      // Reset in the middle of an IO wait.
      @(negedge clk);
      breq = 1'b1; mem_w = 1'b0; addr_in = 32'hE000_0008;
      @(posedge clk);
      @(negedge clk);
      breq = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rstmid_io_sel", {31'b0, io_sel}, 32'h0);
      check("rstmid_busy", {31'b0, busy}, 32'h0);
      check("rstmid_ready", {31'b0, MIO_ready}, 32'h0);
      reset = 1'b0; io_ack = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("late_ack_ready", {31'b0, MIO_ready}, 32'h0);
         check("late_ack_busy", {31'b0, busy}, 32'h0);
      end
      io_ack = 1'b0;

      for (int n = 0; n < 60; n++) begin
         a = $urandom;
         if ($urandom_range(0, 2) == 0) a[31:29] = 3'b111;
         else if (a[31:29] == 3'b111) a[31] = 1'b0;
         if (a[31:29] != 3'b111 && $urandom_range(0, 1) == 1) a = {a[31:14], 4'h0, a[9:0]};
         do_txn(1'($urandom), a, $urandom, $urandom_range(0, IO_TIMEOUT + 2),
                1'($urandom), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
